// File: rtl/config_shift_loader.sv
// -----------------------------------------------------------------------------
// config_shift_loader
//
// Serial configuration loader for the HINP chip family. A parallel config word
// is latched when a start request is accepted in IDLE. The word is then shifted
// out MSB-first on sinp. sclk is generated by dividing clk: each bit takes
// 2*HALF_PER clk cycles, HALF_PER low and then HALF_PER high. busy covers the
// whole transfer. done pulses for one cycle in the first idle cycle afterwards,
// and a new start is accepted in that same cycle.
//
// Parameters
//   CFG_W     config word width / chip chain length (>= 2)
//   HALF_PER  sclk half-period in clk cycles (>= 1)
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-high reset
//   start     transfer request, only looked at while idle
//   cfg_word  config word, latched on an accepted start
//   busy      high while a transfer is in progress
//   done      one-cycle completion pulse
//   sinp      serial data to the chip
//   sclk      serial clock to the chip
//   sout      chain return from the chip        (CFG_READBACK_EN only)
//   rb_word   captured chain return             (CFG_READBACK_EN only)
//   rb_err    returned word != previous load    (CFG_READBACK_EN only)
//
// Build option
//   CFG_READBACK_EN  When defined, the chain return is captured and compared
//                    against the previously loaded word. When undefined, the
//                    readback ports and logic are absent. Serial output timing
//                    is identical in both builds.
// -----------------------------------------------------------------------------
module config_shift_loader #(
  parameter int CFG_W    = 48,
  parameter int HALF_PER = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CFG_W-1:0] cfg_word,
  output logic             busy,
  output logic             done,
  output logic             sinp,
  output logic             sclk
`ifdef CFG_READBACK_EN
  ,
  input  logic             sout,
  output logic [CFG_W-1:0] rb_word,
  output logic             rb_err
`endif
);

  localparam int PH_W = $clog2(HALF_PER + 1);
  localparam int BC_W = $clog2(CFG_W);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PER - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(CFG_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [BC_W-1:0]    bitcnt_q, bitcnt_d;
  logic [CFG_W-1:0]   shreg_q, shreg_d;
  logic               done_d;
  logic               phase_end;

  assign phase_end = (phase_q == PH_LAST);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d  = cfg_word;
          bitcnt_d = BC_LAST;
          phase_d  = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (phase_end) begin
          phase_d = '0;
          state_d = HIGH;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      HIGH: begin
        if (phase_end) begin
          phase_d = '0;
          if (bitcnt_q != '0) begin
            // The next bit is presented in the same cycle sclk falls.
            bitcnt_d = bitcnt_q - BC_W'(1);
            shreg_d  = {shreg_q[CFG_W-2:0], 1'b0};
            state_d  = SETUP;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The outputs are registered from the next-state values. This keeps sclk and
  // sinp glitch-free at the pins and still aligned with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sclk     <= 1'b0;
      sinp     <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      busy     <= (state_d != IDLE);
      done     <= done_d;
      sclk     <= (state_d == HIGH);
      sinp     <= (state_d != IDLE) && shreg_d[CFG_W-1];
    end
  end

`ifdef CFG_READBACK_EN
  logic [CFG_W-1:0] latched_q;
  logic [CFG_W-1:0] prev_word_q;
  logic [CFG_W-1:0] rb_next;
  logic             rb_sample;

  // sout is taken in the first cycle of each high phase, the cycle sclk rises.
  assign rb_sample = (state_q == HIGH) && (phase_q == '0);
  // Compare against rb_next rather than rb_word. With HALF_PER=1 the last bit
  // arrives in the same cycle as completion.
  assign rb_next   = rb_sample ? {rb_word[CFG_W-2:0], sout} : rb_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rb_word     <= '0;
      rb_err      <= 1'b0;
      latched_q   <= '0;
      prev_word_q <= '0;
    end else begin
      rb_word <= rb_next;
      if ((state_q == IDLE) && start) begin
        latched_q <= cfg_word;
      end
      if (done_d) begin
        rb_err      <= (rb_next != prev_word_q);
        prev_word_q <= latched_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_config_shift_loader.sv
module tb_config_shift_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Instance A: CFG_W=8, HALF_PER=2
  logic       start_a = 1'b0;
  logic [7:0] cfg_a = '0;
  logic       busy_a, done_a, sinp_a, sclk_a;
  // Instance B: CFG_W=2, HALF_PER=1
  logic       start_b = 1'b0;
  logic [1:0] cfg_b = '0;
  logic       busy_b, done_b, sinp_b, sclk_b;
  // Instance C: CFG_W=48, HALF_PER=10
  logic        start_c = 1'b0;
  logic [47:0] cfg_c = '0;
  logic        busy_c, done_c, sinp_c, sclk_c;

  int checks = 0;
  int errors = 0;

`ifdef CFG_READBACK_EN
  logic [7:0]  rb_word_a;
  logic        rb_err_a;
  logic [1:0]  rb_word_b;
  logic        rb_err_b;
  logic [47:0] rb_word_c;
  logic        rb_err_c;
  logic        sout_a;
  logic        flip = 1'b0;
  logic [7:0]  chain;
  logic        held;

  // 8-bit chip chain model. Data enters on the sclk rise and shifts on the fall.
  // sout shows the bit that is leaving the chain.
  always @(posedge sclk_a) held <= sinp_a;
  always @(negedge sclk_a or posedge reset)
    if (reset) chain <= '0;
    else       chain <= {chain[6:0], held};
  assign sout_a = chain[7] ^ flip;
`endif

  config_shift_loader #(.CFG_W(8), .HALF_PER(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .cfg_word(cfg_a),
    .busy(busy_a), .done(done_a), .sinp(sinp_a), .sclk(sclk_a)
`ifdef CFG_READBACK_EN
    , .sout(sout_a), .rb_word(rb_word_a), .rb_err(rb_err_a)
`endif
  );

  config_shift_loader #(.CFG_W(2), .HALF_PER(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .cfg_word(cfg_b),
    .busy(busy_b), .done(done_b), .sinp(sinp_b), .sclk(sclk_b)
`ifdef CFG_READBACK_EN
    , .sout(1'b0), .rb_word(rb_word_b), .rb_err(rb_err_b)
`endif
  );

  config_shift_loader #(.CFG_W(48), .HALF_PER(10)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .cfg_word(cfg_c),
    .busy(busy_c), .done(done_c), .sinp(sinp_c), .sclk(sclk_c)
`ifdef CFG_READBACK_EN
    , .sout(1'b0), .rb_word(rb_word_c), .rb_err(rb_err_c)
`endif
  );

  // Reference: expected {busy,done,sclk,sinp} in the cycle that is rel cycles
  // after the first busy cycle of a transfer of 'word' (w bits, half period hp).
  function automatic logic [3:0] model(int w, int hp, logic [47:0] word, int rel);
    int idx;
    int ph;
    if (rel < 0) return 4'b0000;
    if (rel < 2 * hp * w) begin
      idx = rel / (2 * hp);
      ph  = rel % (2 * hp);
      return {1'b1, 1'b0, (ph >= hp), word[w - 1 - idx]};
    end
    if (rel == 2 * hp * w) return 4'b0100;
    return 4'b0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy_a, done_a, sclk_a, sinp_a, busy_b, done_b, sclk_b, sinp_b,
         busy_c, done_c, sclk_c, sinp_c} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got %b %b %b want 0000 each",
               {busy_a, done_a, sclk_a, sinp_a}, {busy_b, done_b, sclk_b, sinp_b},
               {busy_c, done_c, sclk_c, sinp_c});
    end
`ifdef CFG_READBACK_EN
    checks++;
    if ({rb_word_a, rb_err_a} !== 9'h000) begin
      errors++;
      $display("FAIL reset_readback got rb_word=%h rb_err=%b want 00 0", rb_word_a, rb_err_a);
    end
`endif
    reset = 1'b0;
    tick();
  endtask

  task automatic test_patterns();
    logic [7:0] word;
    logic [7:0] bits;
    logic       prev_sclk;
    for (int k = 0; k < 6; k++) begin
      word = (k == 0) ? 8'hA5 : 8'($urandom);
      start_a = 1'b1;
      cfg_a   = word;
      tick();
      start_a = 1'b0;
      bits = '0;
      prev_sclk = 1'b0;
      for (int r = 0; r <= 33; r++) begin
        cfg_a = 8'($urandom);
        checks++;
        if ({busy_a, done_a, sclk_a, sinp_a} !== model(8, 2, {40'd0, word}, r)) begin
          errors++;
          $display("FAIL pattern word=%h rel=%0d got bdcs=%b want %b", word, r,
                   {busy_a, done_a, sclk_a, sinp_a}, model(8, 2, {40'd0, word}, r));
        end
        if (sclk_a && !prev_sclk) bits = {bits[6:0], sinp_a};
        prev_sclk = sclk_a;
        tick();
      end
      checks++;
      if (bits !== word) begin
        errors++;
        $display("FAIL pattern_bits_at_rise got %h want %h", bits, word);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w1;
    logic [7:0] w2;
    w1 = 8'($urandom);
    w2 = 8'($urandom);
    start_a = 1'b1;
    cfg_a   = w1;
    tick();
    start_a = 1'b0;
    for (int r = 0; r <= 32; r++) begin
      checks++;
      if ({busy_a, done_a, sclk_a, sinp_a} !== model(8, 2, {40'd0, w1}, r)) begin
        errors++;
        $display("FAIL b2b_first rel=%0d got %b want %b", r,
                 {busy_a, done_a, sclk_a, sinp_a}, model(8, 2, {40'd0, w1}, r));
      end
      cfg_a = 8'($urandom);
      if (r == 10) start_a = 1'b1;
      if (r == 11) start_a = 1'b0;
      if (r >= 20) start_a = 1'b1;
      if (r == 32) cfg_a = w2;
      tick();
    end
    start_a = 1'b0;
    for (int r = 0; r <= 33; r++) begin
      cfg_a = 8'($urandom);
      checks++;
      if ({busy_a, done_a, sclk_a, sinp_a} !== model(8, 2, {40'd0, w2}, r)) begin
        errors++;
        $display("FAIL b2b_second rel=%0d got %b want %b", r,
                 {busy_a, done_a, sclk_a, sinp_a}, model(8, 2, {40'd0, w2}, r));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    w = 8'($urandom) | 8'h10;
    start_a = 1'b1;
    cfg_a   = w;
    tick();
    start_a = 1'b0;
    for (int r = 0; r < 13; r++) tick();
    // Now at rel 13, inside bit 3. Assert reset between clock edges.
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy_a, done_a, sclk_a, sinp_a} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_immediate got %b want 0000", {busy_a, done_a, sclk_a, sinp_a});
    end
    tick();
    reset = 1'b0;
    for (int r = 0; r < 40; r++) begin
      checks++;
      if ({busy_a, done_a, sclk_a, sinp_a} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_mid_quiet cyc=%0d got %b want 0000", r, {busy_a, done_a, sclk_a, sinp_a});
      end
      tick();
    end
    w = 8'($urandom);
    start_a = 1'b1;
    cfg_a   = w;
    tick();
    start_a = 1'b0;
    for (int r = 0; r <= 33; r++) begin
      checks++;
      if ({busy_a, done_a, sclk_a, sinp_a} !== model(8, 2, {40'd0, w}, r)) begin
        errors++;
        $display("FAIL reset_mid_reload rel=%0d got %b want %b", r,
                 {busy_a, done_a, sclk_a, sinp_a}, model(8, 2, {40'd0, w}, r));
      end
      tick();
    end
  endtask

`ifdef CFG_READBACK_EN
  task automatic test_readback();
    logic [7:0] words [3];
    logic [7:0] exp_rb [3];
    logic       exp_err [3];
    words   = '{8'hA5, 8'h3C, 8'h5A};
    exp_rb  = '{8'h00, 8'hA5, 8'hBC};
    exp_err = '{1'b0, 1'b0, 1'b1};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      start_a = 1'b1;
      cfg_a   = words[k];
      if (k == 2) flip = 1'b1;
      tick();
      start_a = 1'b0;
      for (int r = 0; r < 32; r++) begin
        if (r == 4) flip = 1'b0;
        tick();
      end
      checks++;
      if ({done_a, rb_word_a, rb_err_a} !== {1'b1, exp_rb[k], exp_err[k]}) begin
        errors++;
        $display("FAIL readback_%0d got done=%b rb_word=%h rb_err=%b want 1 %h %b",
                 k, done_a, rb_word_a, rb_err_a, exp_rb[k], exp_err[k]);
      end
      for (int r = 0; r < 5; r++) tick();
      checks++;
      if ({rb_word_a, rb_err_a} !== {exp_rb[k], exp_err[k]}) begin
        errors++;
        $display("FAIL readback_hold_%0d got rb_word=%h rb_err=%b want %h %b",
                 k, rb_word_a, rb_err_a, exp_rb[k], exp_err[k]);
      end
    end
  endtask
`endif

  task automatic test_edge_min();
    logic [1:0] w;
    start_b = 1'b1;
    for (int k = 0; k < 5; k++) begin
      w = 2'($urandom);
      if (k == 0) w = 2'b10;
      cfg_b = w;
      tick();
      for (int r = 0; r <= 4; r++) begin
        checks++;
        if ({busy_b, done_b, sclk_b, sinp_b} !== model(2, 1, {46'd0, w}, r)) begin
          errors++;
          $display("FAIL edge_min k=%0d rel=%0d got %b want %b", k, r,
                   {busy_b, done_b, sclk_b, sinp_b}, model(2, 1, {46'd0, w}, r));
        end
        if (r == 4 && k == 4) start_b = 1'b0;
        if (r < 4) begin
          cfg_b = 2'($urandom);
          tick();
        end
      end
    end
    tick();
    checks++;
    if ({busy_b, done_b, sclk_b, sinp_b} !== 4'b0000) begin
      errors++;
      $display("FAIL edge_min_idle got %b want 0000", {busy_b, done_b, sclk_b, sinp_b});
    end
  endtask

  task automatic test_long();
    logic [47:0] w;
    logic [47:0] bits;
    int          rises;
    int          first_rise;
    logic        prev_sclk;
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? 48'h01_00_00_00_00_00 : {16'($urandom), 32'($urandom)};
      start_c = 1'b1;
      cfg_c   = w;
      tick();
      start_c = 1'b0;
      bits = '0;
      rises = 0;
      first_rise = -1;
      prev_sclk = 1'b0;
      for (int r = 0; r <= 961; r++) begin
        checks++;
        if ({busy_c, done_c, sclk_c, sinp_c} !== model(48, 10, w, r)) begin
          errors++;
          $display("FAIL long rel=%0d got %b want %b", r,
                   {busy_c, done_c, sclk_c, sinp_c}, model(48, 10, w, r));
        end
        if (sclk_c && !prev_sclk) begin
          bits = {bits[46:0], sinp_c};
          if (rises == 0) first_rise = r;
          rises++;
        end
        prev_sclk = sclk_c;
        tick();
      end
      checks++;
      if (rises !== 48 || first_rise !== 10 || bits !== w) begin
        errors++;
        $display("FAIL long_summary rises=%0d first_rel=%0d bits=%h want 48 10 %h",
                 rises, first_rise, bits, w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_back_to_back();
    test_reset_mid();
`ifdef CFG_READBACK_EN
    test_readback();
`endif
    test_edge_min();
    test_long();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
